updown_load_counter: RTL and testbench
======================================

Name: updown_load_counter

Overview:
- Synchronous WIDTH-bit up/down counter with parallel load and a one-cycle rollover flag.
- Used as the leaf behind the team's counter interface. A thin interface-wrapper top binds the interface signals to this module's flat ports.
- Single clock domain; no handshakes.

Parameters:
- WIDTH, 8, bit width of data and count.

Ports:
- clk  input  1  rising-edge clock.
- srst_n  input  1  asynchronous active-low reset.
- load  input  1  parallel-load enable; highest-priority control.
- up  input  1  increment enable.
- down  input  1  decrement enable.
- data  input  WIDTH  parallel-load value.
- rollover  output  1  registered wrap flag, one cycle.
- count  output  WIDTH  registered counter value.

Behaviour:
- Reset:
  - srst_n=0 immediately forces count=0 and rollover=0, independent of clk.
  - Outputs hold these values while srst_n=0.
  - Deassertion takes effect on the next rising clk edge.
  - Reset asserted mid-count clears at once; counting resumes from 0 after release.
- Per rising clk edge with srst_n=1, evaluated in priority order:
  1. load=1: count<=data; rollover<=0. up and down are ignored.
  2. up=1, down=0: count<=count+1, modulo 2^WIDTH.
     - If count was all-ones, count<=0 and rollover<=1.
     - Otherwise rollover<=0.
  3. down=1, up=0: count<=count-1, modulo 2^WIDTH.
     - If count was 0, count<=all-ones and rollover<=1.
     - Otherwise rollover<=0.
  4. up=1, down=1: count holds; rollover<=0.
  5. No enable: count holds; rollover<=0.
- Latency: one clock. The new count and its rollover flag appear together after the edge that sampled the controls.
- rollover timing:
  - High for exactly one cycle per wrap event.
  - Stays high every cycle while continuous wrapping occurs (e.g. WIDTH=1 counting up).
- Holding load=1 with constant data keeps count=data every cycle.
- Inputs are sampled only at rising clk edges; there is no combinational path from inputs to outputs.
- X/Z on any control input while srst_n=1 is a verification error; the design need not define the result.

Decomposition:
- Package counter_pkg:
  - localparam COUNT_W=8, the default WIDTH.
  - typedef count_t = logic [COUNT_W-1:0].
  - Optional enum ctrl_e {CTRL_LOAD, CTRL_UP, CTRL_DOWN, CTRL_HOLD} for the priority decode.
- Interface counter_if:
  - Carries clk, srst_n, load, up, down, data, rollover and count.
  - Modports dut and tb.
- Sub-module: none inside the core.
  - The interface wrapper counter_wif is the natural single level above.
  - It instantiates updown_load_counter and maps ports one-to-one.
- Core structure: a combinational next-state/decode block plus one always_ff holding count and rollover.

Test Plan:
- Reset: hold srst_n=0 for 10 cycles with random up/down/load -> count=0x00 and rollover=0 throughout. Release, idle 2 cycles -> count stays 0x00.
- Count up then down: up=1 for 10 cycles -> count=0x0A, rollover never set. Then up=0, down=1 for 5 cycles -> count=0x05.
- Load and priority:
  - load=1, data=0xAA for 2 cycles -> count=0xAA, holds 0xAA while load stays 1.
  - load=1, up=1, data=0x33 -> count=0x33, not 0x34.
- Wrap up: load 0xFE, then up=1 for 3 cycles -> count 0xFF, 0x00, 0x01. rollover=1 only in the cycle count=0x00.
- Wrap down and conflict:
  - load 0x01, then down=1 for 3 cycles -> count 0x00, 0xFF, 0xFE. rollover=1 only with 0xFF.
  - up=down=1 from count=0xFE -> count holds 0xFE, rollover=0.
- Async reset mid-operation: count=0x7F with up=1, pulse srst_n low between clock edges -> count=0x00 immediately, before the next edge. After release, up=1 for 4 edges -> count=0x04.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types for the up/down/load counter.
// Latency: n/a (types and a pure decode function only).
// Backpressure: none; there are no handshakes anywhere in this counter.
package counter_pkg;

  localparam int COUNT_W = 8;

  typedef logic [COUNT_W-1:0] count_t;

  // One-hot-free priority decode result: load beats up/down, conflicts hold.
  typedef enum logic [1:0] {
    CTRL_LOAD,
    CTRL_UP,
    CTRL_DOWN,
    CTRL_HOLD
  } ctrl_e;

  function automatic ctrl_e ctrl_decode(input logic load, input logic up, input logic down);
    ctrl_e c;
    if (load)             c = CTRL_LOAD;
    else if (up && !down) c = CTRL_UP;
    else if (down && !up) c = CTRL_DOWN;
    else                  c = CTRL_HOLD;  // up==down: both idle or both set
    return c;
  endfunction

endpackage

// File: rtl/counter_if.sv
// Bundle of the counter's flat signals for benches and wrappers.
// Latency: n/a (wires only).
// Backpressure: none.
// Ports: clk (shared clock, supplied by the instantiating scope).
interface counter_if #(
  parameter int WIDTH = counter_pkg::COUNT_W
) (
  input logic clk
);
  logic             srst_n;
  logic             load;
  logic             up;
  logic             down;
  logic [WIDTH-1:0] data;
  logic             rollover;
  logic [WIDTH-1:0] count;

  modport dut (
    input  clk, srst_n, load, up, down, data,
    output rollover, count
  );

  modport tb (
    input  clk, rollover, count,
    output srst_n, load, up, down, data
  );
endinterface

// File: rtl/updown_load_counter.sv
// WIDTH-bit up/down counter with parallel load and a one-cycle wrap flag.
// Latency: one clock; count and rollover update together on the sampling edge.
// Backpressure: none; controls are sampled every rising edge.
// Ports: clk, srst_n (async active-low), load/up/down controls, data (load value),
//        count (registered value), rollover (registered wrap flag).
module updown_load_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNT_W
) (
  input  logic             clk,
  input  logic             srst_n,
  input  logic             load,
  input  logic             up,
  input  logic             down,
  input  logic [WIDTH-1:0] data,
  output logic             rollover,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             rollover_q, rollover_d;
  ctrl_e            ctrl;

  always_comb begin
    ctrl       = ctrl_decode(load, up, down);
    count_d    = count_q;
    rollover_d = 1'b0;
    case (ctrl)
      CTRL_LOAD: count_d = data;
      CTRL_UP: begin
        count_d    = count_q + WIDTH'(1);
        // Wrap is flagged from the pre-increment value so it lines up with count=0.
        rollover_d = (count_q == {WIDTH{1'b1}});
      end
      CTRL_DOWN: begin
        count_d    = count_q - WIDTH'(1);
        rollover_d = (count_q == {WIDTH{1'b0}});
      end
      default: ;  // hold
    endcase
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      count_q    <= '0;
      rollover_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      rollover_q <= rollover_d;
    end
  end

  assign count    = count_q;
  assign rollover = rollover_q;

endmodule

// File: tb/tb_updown_load_counter.sv
module tb_updown_load_counter;
  import counter_pkg::*;

  localparam int W = COUNT_W;

  typedef struct {
    logic [W-1:0] cnt;
    logic         roll;
    string        name;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  counter_if #(.WIDTH(W)) cif (.clk(clk));

  updown_load_counter #(.WIDTH(W)) dut (
    .clk      (cif.clk),
    .srst_n   (cif.srst_n),
    .load     (cif.load),
    .up       (cif.up),
    .down     (cif.down),
    .data     (cif.data),
    .rollover (cif.rollover),
    .count    (cif.count)
  );

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [W-1:0] cnt, input logic roll,
                       input logic [W-1:0] ecnt, input logic eroll);
    checks++;
    if (cnt !== ecnt || roll !== eroll) begin
      errors++;
      $display("FAIL %s: got count=%02h rollover=%b, expected count=%02h rollover=%b",
               name, cnt, roll, ecnt, eroll);
    end
  endtask

  // Monitor: one registered result per rising edge, compared against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, cif.count, cif.rollover, e.cnt, e.roll);
      end
    end
  end

  // Drive controls mid-cycle and queue what the following edge must produce.
  task automatic step(input logic ld, input logic u, input logic d, input logic [W-1:0] dat,
                      input logic [W-1:0] ecnt, input logic eroll, input string name);
    exp_t e;
    @(negedge clk);
    cif.load = ld;
    cif.up   = u;
    cif.down = d;
    cif.data = dat;
    e.cnt  = ecnt;
    e.roll = eroll;
    e.name = name;
    exp_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    cif.srst_n = 1'b0;
    cif.load   = 1'b0;
    cif.up     = 1'b0;
    cif.down   = 1'b0;
    cif.data   = '0;

    // Reset held with random controls: outputs stay cleared.
    for (int i = 0; i < 10; i++)
      step(1'($urandom), 1'($urandom), 1'($urandom), W'($urandom), 8'h00, 1'b0, "reset_hold");

    @(negedge clk);
    cif.srst_n = 1'b1;
    cif.load = 1'b0; cif.up = 1'b0; cif.down = 1'b0;
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "post_reset_idle0");
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "post_reset_idle1");

    // Count up 10, then down 5.
    for (int i = 1; i <= 10; i++)
      step(1'b0, 1'b1, 1'b0, 8'h00, W'(i), 1'b0, "count_up");
    for (int i = 9; i >= 5; i--)
      step(1'b0, 1'b0, 1'b1, 8'h00, W'(i), 1'b0, "count_down");

    // Load and priority over up.
    step(1'b1, 1'b0, 1'b0, 8'hAA, 8'hAA, 1'b0, "load_aa");
    step(1'b1, 1'b0, 1'b0, 8'hAA, 8'hAA, 1'b0, "load_aa_hold");
    step(1'b1, 1'b1, 1'b0, 8'h33, 8'h33, 1'b0, "load_beats_up");

    // Wrap upward.
    step(1'b1, 1'b0, 1'b0, 8'hFE, 8'hFE, 1'b0, "load_fe");
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0, "up_to_ff");
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, "up_wrap");
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0, "up_after_wrap");

    // Wrap downward, then conflicting enables.
    step(1'b1, 1'b0, 1'b0, 8'h01, 8'h01, 1'b0, "load_01");
    step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, "down_to_00");
    step(1'b0, 1'b0, 1'b1, 8'h00, 8'hFF, 1'b1, "down_wrap");
    step(1'b0, 1'b0, 1'b1, 8'h00, 8'hFE, 1'b0, "down_after_wrap");
    step(1'b0, 1'b1, 1'b1, 8'h00, 8'hFE, 1'b0, "up_down_conflict");
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'hFE, 1'b0, "idle_hold");

    // Async reset pulse between edges while counting from 0x7F.
    step(1'b1, 1'b0, 1'b0, 8'h7F, 8'h7F, 1'b0, "load_7f");
    @(negedge clk);
    cif.load = 1'b0; cif.up = 1'b1; cif.down = 1'b0;
    #1;
    cif.srst_n = 1'b0;
    #1;
    check("async_reset_immediate", cif.count, cif.rollover, 8'h00, 1'b0);
    #1;
    cif.srst_n = 1'b1;
    e.cnt = 8'h01; e.roll = 1'b0; e.name = "resume_after_reset";
    exp_q.push_back(e);
    for (int i = 2; i <= 4; i++)
      step(1'b0, 1'b1, 1'b0, 8'h00, W'(i), 1'b0, "resume_up");

    // Let the monitor drain the last expectation.
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
